// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave with a NUM_REGS x 8 register file, auto-incrementing
// register pointer and a digital glitch filter on SCL/SDA.
// Optional feature macro: I2C_SLAVE_GENCALL_EN (ACK general-call writes to address 7'h00).
module i2c_slave_regfile #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h51,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned FILT_LEN   = 3,
    parameter logic [7:0]  RST_VAL    = 8'h00,
    localparam int unsigned PTR_W     = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    scl,
    input  logic                    sda_in,
    output logic                    sda_out,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic                    wr_strobe,
    output logic [PTR_W-1:0]        wr_index,
    output logic                    busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BCNT_W = 4;
    localparam int unsigned LINE_SCL = 0;
    localparam int unsigned LINE_SDA = 1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // Input conditioning: index 0 = SCL, index 1 = SDA
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       filt_q;
    logic [1:0]       prev_q;
    logic [CNT_W-1:0] fcnt_q [2];

    // Protocol state
    state_t                state_q;
    logic [BCNT_W-1:0]     bit_cnt_q;
    logic [7:0]            shift_q;
    logic                  phase_q;
    logic                  rw_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [NUM_REGS*8-1:0] regs_q;
    logic                  sda_out_q;
    logic                  wr_strobe_q;
    logic [PTR_W-1:0]      wr_index_q;
    logic                  busy_q;

    // Decoded events and helpers
    logic             scl_rise_c;
    logic             scl_fall_c;
    logic             start_c;
    logic             stop_c;
    logic [7:0]       byte_c;
    logic             addr_match_c;
    logic             ptr_ok_c;
    logic [PTR_W-1:0] ptr_inc_c;
    logic [7:0]       rd_byte_c;
    logic [7:0]       rd_next_c;

    // Two-flop synchroniser followed by a FILT_LEN-sample persistence filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {sda_in, scl};
            sync2_q <= sync1_q;
            prev_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign scl_rise_c = filt_q[LINE_SCL] & ~prev_q[LINE_SCL];
    assign scl_fall_c = ~filt_q[LINE_SCL] & prev_q[LINE_SCL];
    assign start_c    = ~filt_q[LINE_SDA] & prev_q[LINE_SDA] & filt_q[LINE_SCL] & prev_q[LINE_SCL];
    assign stop_c     = filt_q[LINE_SDA] & ~prev_q[LINE_SDA] & filt_q[LINE_SCL] & prev_q[LINE_SCL];

    assign byte_c    = {shift_q[6:0], filt_q[LINE_SDA]};
    assign ptr_ok_c  = ({1'b0, byte_c} < 9'(NUM_REGS));
    assign ptr_inc_c = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign rd_byte_c = regs_q[{ptr_q, 3'b000} +: 8];
    assign rd_next_c = regs_q[{ptr_inc_c, 3'b000} +: 8];

`ifdef I2C_SLAVE_GENCALL_EN
    // General call: address 7'h00 is accepted for writes only
    assign addr_match_c = (byte_c[7:1] == SLAVE_ADDR) || (byte_c == 8'h00);
`else
    assign addr_match_c = (byte_c[7:1] == SLAVE_ADDR);
`endif

    // Protocol FSM, register file and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            ptr_q       <= '0;
            regs_q      <= {NUM_REGS{RST_VAL}};
            sda_out_q   <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (stop_c) begin
                state_q   <= IDLE;
                sda_out_q <= 1'b1;
                busy_q    <= 1'b0;
                phase_q   <= 1'b0;
            end else if (start_c) begin
                state_q   <= ADDR;
                bit_cnt_q <= '0;
                sda_out_q <= 1'b1;
                phase_q   <= 1'b0;
            end else if (scl_rise_c) begin
                case (state_q)
                    ADDR: begin
                        shift_q <= byte_c;
                        if (bit_cnt_q == BCNT_W'(7)) begin
                            bit_cnt_q <= '0;
                            if (addr_match_c) begin
                                state_q <= ADDR_ACK;
                                busy_q  <= 1'b1;
                                rw_q    <= byte_c[0];
                                phase_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        end
                    end
                    PTR: begin
                        shift_q <= byte_c;
                        if (bit_cnt_q == BCNT_W'(7)) begin
                            bit_cnt_q <= '0;
                            if (ptr_ok_c) begin
                                ptr_q   <= PTR_W'(byte_c);
                                state_q <= PTR_ACK;
                                phase_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        end
                    end
                    WDATA: begin
                        shift_q <= byte_c;
                        if (bit_cnt_q == BCNT_W'(7)) begin
                            bit_cnt_q                    <= '0;
                            regs_q[{ptr_q, 3'b000} +: 8] <= byte_c;
                            wr_strobe_q                  <= 1'b1;
                            wr_index_q                   <= ptr_q;
                            ptr_q                        <= ptr_inc_c;
                            state_q                      <= WDATA_ACK;
                            phase_q                      <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        end
                    end
                    RDATA_ACK: begin
                        // Master NACK ends the read; ACK arms the reload on the next fall
                        if (filt_q[LINE_SDA]) begin
                            state_q <= IDLE;
                        end else begin
                            phase_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall_c) begin
                case (state_q)
                    ADDR_ACK: begin
                        if (!phase_q) begin
                            sda_out_q <= 1'b0;
                            phase_q   <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (rw_q) begin
                                shift_q   <= {rd_byte_c[6:0], 1'b0};
                                sda_out_q <= rd_byte_c[7];
                                bit_cnt_q <= BCNT_W'(1);
                                state_q   <= RDATA;
                            end else begin
                                sda_out_q <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (!phase_q) begin
                            sda_out_q <= 1'b0;
                            phase_q   <= 1'b1;
                        end else begin
                            sda_out_q <= 1'b1;
                            phase_q   <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (bit_cnt_q == BCNT_W'(8)) begin
                            sda_out_q <= 1'b1;
                            phase_q   <= 1'b0;
                            state_q   <= RDATA_ACK;
                        end else begin
                            sda_out_q <= shift_q[7];
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                        end
                    end
                    RDATA_ACK: begin
                        if (phase_q) begin
                            ptr_q     <= ptr_inc_c;
                            shift_q   <= {rd_next_c[6:0], 1'b0};
                            sda_out_q <= rd_next_c[7];
                            bit_cnt_q <= BCNT_W'(1);
                            phase_q   <= 1'b0;
                            state_q   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_out   = sda_out_q;
    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign busy      = busy_q;

endmodule
